// File: rtl/vlsu_store_seq_pkg.sv
// rtl/vlsu_store_seq_pkg.sv - shared constants, state encoding and slot-suppress rule
package vlsu_store_seq_pkg;
  localparam int MAXVL        = 64;
  localparam int VL_W         = 7;
  localparam int PC_ADDR_BITS = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_ISSUE = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  // Low bits for an inactive slot: never equal to the slot number, so its bank stays off.
  function automatic logic [1:0] suppress_lsb(input logic [1:0] slot);
    return slot + 2'd1;
  endfunction
endpackage

// File: rtl/vlsu_addr_gen.sv
// rtl/vlsu_addr_gen.sv - running store-address accumulator (load base, add step per beat, wrap)
module vlsu_addr_gen
  import vlsu_store_seq_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_BITS
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_step_en,
  input  logic [ADDR_W-1:0] i_step,
  output logic [ADDR_W-1:0] o_addr
);
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_step_en) begin
      r_addr <= r_addr + i_step;
    end
  end

  assign o_addr = r_addr;
endmodule

// File: rtl/vlsu_store_seq.sv
// rtl/vlsu_store_seq.sv - vector store sequencer: VRF group reads, slot address/data muxing
module vlsu_store_seq
  import vlsu_store_seq_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_BITS
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [31:0]       i_stride,
  input  logic              i_strided,
  input  logic [VL_W-1:0]   i_vl,
  input  logic              i_stall,
  output logic              o_vrf_rd_en,
  output logic [VL_W-3:0]   o_vrf_rd_grp,
  input  logic [31:0]       i_vrf_data_0,
  input  logic [31:0]       i_vrf_data_1,
  input  logic [31:0]       i_vrf_data_2,
  input  logic [31:0]       i_vrf_data_3,
  output logic              o_vs_valid,
  output logic [ADDR_W-1:0] o_addr_0,
  output logic [ADDR_W-1:0] o_addr_1,
  output logic [ADDR_W-1:0] o_addr_2,
  output logic [ADDR_W-1:0] o_addr_3,
  output logic [31:0]       o_data_0,
  output logic [31:0]       o_data_1,
  output logic [31:0]       o_data_2,
  output logic [31:0]       o_data_3,
  output logic              o_busy,
  output logic              o_done
);
  state_e            r_state, w_next;
  logic [VL_W-1:0]   r_vl, r_elem;
  logic [VL_W-3:0]   r_group;
  logic              r_fast, r_fresh;
  logic [ADDR_W-1:0] r_step;
  logic [31:0]       r_vdata  [4];
  logic [ADDR_W-1:0] r_addr_q [4];
  logic [31:0]       r_data_q [4];

  logic [31:0]       w_vrf_in [4];
  logic [31:0]       w_src    [4];
  logic [ADDR_W-1:0] w_addr   [4];
  logic [31:0]       w_data   [4];
  logic [ADDR_W-1:0] w_cur;
  logic [VL_W-1:0]   w_vl_clamp, w_elem_nxt, w_idx;
  logic [VL_W-3:0]   w_grp_inc;
  logic              w_accept, w_issue, w_fast_start, w_last_grp;

  assign w_vrf_in[0]  = i_vrf_data_0;
  assign w_vrf_in[1]  = i_vrf_data_1;
  assign w_vrf_in[2]  = i_vrf_data_2;
  assign w_vrf_in[3]  = i_vrf_data_3;

  assign w_accept     = (r_state == S_IDLE) && i_start && !i_stall;
  assign w_issue      = (r_state == S_ISSUE) && !i_stall;
  assign w_vl_clamp   = (i_vl > VL_W'(MAXVL)) ? VL_W'(MAXVL) : i_vl;
  assign w_fast_start = (!i_strided || (i_stride == 32'd1)) && (i_base_addr[1:0] == 2'b00);
  assign w_elem_nxt   = r_elem + 1'b1;
  assign w_grp_inc    = r_group + 1'b1;
  assign w_last_grp   = {w_grp_inc, 2'b00} >= r_vl;

  vlsu_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .i_load    (w_accept),
    .i_base    (i_base_addr),
    .i_step_en (w_issue),
    .i_step    (r_fast ? ADDR_W'(4) : r_step),
    .o_addr    (w_cur)
  );

  // First ISSUE beat after a READ takes the VRF output directly; later beats use the copy.
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < 4; k++) begin
      w_src[k]  = r_fresh ? w_vrf_in[k] : r_vdata[k];
      w_addr[k] = w_cur;
      w_data[k] = w_src[k];
    end
    for (int k = 0; k < 4; k++) begin
      if (r_fast) begin
        w_idx     = {r_group, 2'b00} + VL_W'(k);
        w_addr[k] = (w_idx >= r_vl) ? {w_cur[ADDR_W-1:2], suppress_lsb(2'(k))}
                                    : w_cur + ADDR_W'(k);
        w_data[k] = w_src[k];
      end else begin
        w_addr[k] = w_cur;
        w_data[k] = w_src[r_elem[1:0]];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_vl_clamp == '0) ? S_FIN : S_READ;
      S_READ:  if (!i_stall) w_next = S_ISSUE;
      S_ISSUE: begin
        if (!i_stall) begin
          if (r_fast)                      w_next = w_last_grp ? S_FIN : S_READ;
          else if (w_elem_nxt == r_vl)     w_next = S_FIN;
          else if (w_elem_nxt[1:0] == 2'b00) w_next = S_READ;
          else                             w_next = S_ISSUE;
        end
      end
      S_FIN:   if (!i_stall) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_vl    <= '0;
      r_elem  <= '0;
      r_group <= '0;
      r_fast  <= 1'b0;
      r_fresh <= 1'b0;
      r_step  <= '0;
      for (int k = 0; k < 4; k++) begin
        r_vdata[k]  <= '0;
        r_addr_q[k] <= '0;
        r_data_q[k] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_vl    <= w_vl_clamp;
        r_elem  <= '0;
        r_group <= '0;
        r_fast  <= w_fast_start;
        r_step  <= i_strided ? i_stride[ADDR_W-1:0] : ADDR_W'(1);
      end
      if ((r_state == S_READ) && !i_stall) r_fresh <= 1'b1;
      if (w_issue) begin
        r_fresh <= 1'b0;
        if (r_fresh) r_vdata <= w_vrf_in;
        r_elem   <= w_elem_nxt;
        if (r_fast || (w_elem_nxt[1:0] == 2'b00)) r_group <= w_grp_inc;
        r_addr_q <= w_addr;
        r_data_q <= w_data;
      end
    end
  end

  assign o_vs_valid   = (r_state == S_ISSUE);
  assign o_vrf_rd_en  = (r_state == S_READ);
  assign o_vrf_rd_grp = r_group;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_FIN);
  assign o_addr_0     = o_vs_valid ? w_addr[0] : r_addr_q[0];
  assign o_addr_1     = o_vs_valid ? w_addr[1] : r_addr_q[1];
  assign o_addr_2     = o_vs_valid ? w_addr[2] : r_addr_q[2];
  assign o_addr_3     = o_vs_valid ? w_addr[3] : r_addr_q[3];
  assign o_data_0     = o_vs_valid ? w_data[0] : r_data_q[0];
  assign o_data_1     = o_vs_valid ? w_data[1] : r_data_q[1];
  assign o_data_2     = o_vs_valid ? w_data[2] : r_data_q[2];
  assign o_data_3     = o_vs_valid ? w_data[3] : r_data_q[3];
endmodule

// File: tb/tb_vlsu_store_seq.sv
// tb/tb_vlsu_store_seq.sv - self-checking bench for vlsu_store_seq against a beat-list reference model
module tb_vlsu_store_seq;
  import vlsu_store_seq_pkg::*;
  localparam int AW = PC_ADDR_BITS;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   stride = '0;
  logic          strided = 1'b0;
  logic [VL_W-1:0] vl = '0;
  logic          stall = 1'b0;
  logic          vrf_rd_en;
  logic [VL_W-3:0] vrf_rd_grp;
  logic [31:0]   vrf_d [4] = '{default: 32'd0};
  logic          vs_valid, busy, done;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   d0, d1, d2, d3;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   mem [64];
  logic [AW-1:0] ea [64][4];
  logic [31:0]   ed [64][4];
  int            nbeats, exp_lat;

  vlsu_store_seq dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_base_addr(base_addr),
    .i_stride(stride), .i_strided(strided), .i_vl(vl), .i_stall(stall),
    .o_vrf_rd_en(vrf_rd_en), .o_vrf_rd_grp(vrf_rd_grp),
    .i_vrf_data_0(vrf_d[0]), .i_vrf_data_1(vrf_d[1]),
    .i_vrf_data_2(vrf_d[2]), .i_vrf_data_3(vrf_d[3]),
    .o_vs_valid(vs_valid),
    .o_addr_0(a0), .o_addr_1(a1), .o_addr_2(a2), .o_addr_3(a3),
    .o_data_0(d0), .o_data_1(d1), .o_data_2(d2), .o_data_3(d3),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // Synchronous VRF: data for the requested group appears the cycle after the request.
  always @(posedge clk) begin
    if (vrf_rd_en) begin
      for (int k = 0; k < 4; k++) vrf_d[k] <= mem[{vrf_rd_grp, 2'b00} + k];
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] obs_beat();
    return {vs_valid, a0, a1, a2, a3, d0, d1, d2, d3};
  endfunction

  function automatic logic [255:0] exp_beat(input int b);
    return {1'b1, ea[b][0], ea[b][1], ea[b][2], ea[b][3], ed[b][0], ed[b][1], ed[b][2], ed[b][3]};
  endfunction

  function automatic logic [255:0] all_outs();
    return {vrf_rd_en, vrf_rd_grp, vs_valid, a0, a1, a2, a3, d0, d1, d2, d3, busy, done};
  endfunction

  // Expected beats straight from the addressing rules: base+e (fast) or base+e*stride (slow).
  task automatic build(input int base, input int str, input bit sd, input int vl_in);
    int n, ng, step, row;
    bit fast;
    n    = (vl_in > MAXVL) ? MAXVL : vl_in;
    ng   = (n + 3) / 4;
    fast = (!sd || str == 1) && (base % 4 == 0);
    if (fast) begin
      for (int g = 0; g < ng; g++) begin
        row = (base + 4 * g) / 4;
        for (int i = 0; i < 4; i++) begin
          ea[g][i] = (4 * g + i < n) ? AW'(base + 4 * g + i) : AW'(row * 4 + (i + 1) % 4);
          ed[g][i] = mem[4 * g + i];
        end
      end
      nbeats  = ng;
      exp_lat = 2 * ng + 1;
    end else begin
      step = sd ? str : 1;
      for (int e = 0; e < n; e++) begin
        for (int i = 0; i < 4; i++) begin
          ea[e][i] = AW'(base + e * step);
          ed[e][i] = mem[e];
        end
      end
      nbeats  = n;
      exp_lat = n + ng + 1;
    end
  endtask

  task automatic run_op(input int base, input int str, input bit sd, input int vl_in,
                        input int stall_beat, input bit busy_start);
    int idx, done_n, done_c, hold, lat;
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    build(base, str, sd, vl_in);
    lat = exp_lat + ((stall_beat >= 0 && stall_beat < nbeats) ? 3 : 0);
    @(posedge clk); #1;
    base_addr = AW'(base); stride = 32'(str); strided = sd; vl = VL_W'(vl_in); start = 1'b1;
    idx = 0; done_n = 0; done_c = -1; hold = 0;
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (busy_start && c == 2) begin start = 1'b1; base_addr = 16'h0007; vl = 7'd3; end
      if (busy_start && c == 3) start = 1'b0;
      if (done) begin done_n++; if (done_c < 0) done_c = c; end
      if (hold > 0) begin
        chk("stall_hold", obs_beat(), exp_beat(idx - 1));
        hold--;
        if (hold == 0) stall = 1'b0;
      end else if (vs_valid) begin
        if (idx < nbeats) chk($sformatf("beat%0d", idx), obs_beat(), exp_beat(idx));
        else              chk("extra_beat", 256'(vs_valid), 256'(0));
        idx++;
        if (idx - 1 == stall_beat) begin stall = 1'b1; hold = 3; end
      end
    end
    chk("beat_count", 256'(idx), 256'(nbeats));
    chk("done_cycle", 256'(done_c), 256'(lat));
    chk("done_pulses", 256'(done_n), 256'(1));
  endtask

  initial begin
    int b, s, v;
    bit sd;
    #2;
    chk("reset_outputs", all_outs(), 256'(0));
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    run_op(32'h100, 0, 1'b0, 8, -1, 1'b0);
    run_op(32'h040, 0, 1'b0, 6, -1, 1'b0);
    run_op(32'h021, 0, 1'b0, 3, -1, 1'b0);
    run_op(32'h010, -3, 1'b1, 5, -1, 1'b0);
    run_op(32'h080, 0, 1'b0, 12, 1, 1'b0);
    run_op(32'h033, 2, 1'b1, 7, 3, 1'b0);
    run_op(32'h055, 0, 1'b0, 0, -1, 1'b0);
    run_op(32'h1000, 0, 1'b0, 100, -1, 1'b0);
    run_op(32'h300, 1, 1'b1, 9, -1, 1'b1);

    // Reset while in READ aborts with no done pulse.
    @(posedge clk); #1;
    base_addr = 16'h0200; strided = 1'b0; vl = 7'd12; start = 1'b1;
    @(negedge clk); @(negedge clk);
    start = 1'b0;
    chk("in_read", 256'(vrf_rd_en), 256'(1));
    nrst = 1'b0;
    #1 chk("abort_outputs", all_outs(), 256'(0));
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 256'({busy, done}), 256'(0));
    end
    nrst = 1'b1;
    run_op(32'h204, 0, 1'b0, 10, -1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      b  = int'($urandom_range(0, 16'hffff));
      if ($urandom_range(0, 1) == 1) b = b & 32'hfffc;
      s  = int'($urandom_range(0, 16)) - 8;
      sd = 1'($urandom_range(0, 1));
      v  = int'($urandom_range(0, 70));
      run_op(b, s, sd, v, (v > 4) ? int'($urandom_range(0, 2)) : -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vlsu_store_seq.md
Name: vlsu_store_seq

Overview:
- Vector store sequencer inside the VLSU, directly upstream of the data-memory store stage.
- On a vector store, it reads 32-bit elements from the VRF and walks the element index.
- Each beat it presents four slot addresses and four slot data words plus a vector-store valid. The store stage enables bank N only when slot N's address satisfies addr[1:0]==N, and takes the shared row address from slot 0.
- Unit-stride stores with an aligned base issue 4 elements per beat (fast mode); all other stores issue 1 element per beat (slow mode).

Parameters:
- MAXVL, 64, maximum vector length in 32-bit elements.
- VL_W, 7, width of vl (must hold MAXVL).
- ADDR_W, `PC_ADDR_BITS (constants.vh), word-address width of the slot address outputs.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- base_addr  in  ADDR_W  word address of element 0; sampled on an accepted start
- stride  in  32  signed word stride; sampled on start; used only when strided=1
- strided  in  1  1 = strided store, 0 = unit-stride; sampled on start
- vl  in  VL_W  element count; sampled on start
- stall  in  1  freeze: state, counters and all outputs hold
- vrf_rd_en  out  1  VRF group-read request
- vrf_rd_grp  out  VL_W-2  element-group index (elements 4g..4g+3)
- vrf_data_0..3  in  32 each  group elements; valid the cycle after vrf_rd_en
- vs_valid  out  1  drives the store stage's is_vstype
- addr_0..3  out  ADDR_W each  slot addresses
- data_0..3  out  32 each  slot data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (nrst low, asynchronous): state IDLE; all outputs 0; element counter, group counter and latched operands cleared.
- Reset mid-operation aborts the operation; no done pulse is produced.
- Mode decision at start:
  - fast = (!strided || stride==1) && base_addr[1:0]==0.
  - Otherwise slow mode.
- States: IDLE, READ, ISSUE, FIN.
- IDLE:
  - start with vl==0 -> FIN.
  - start with vl!=0 -> READ with group=0 and elem=0.
  - start while busy is ignored.
- READ (1 cycle):
  - vrf_rd_en=1 and vrf_rd_grp=group.
  - Next state ISSUE; the VRF data is registered on entry to ISSUE.
- ISSUE, fast mode (1 beat per group):
  - vs_valid=1.
  - Slot i: data_i=elem i of the group; addr_i = base + 4*group + i.
  - Slots whose element index is >= vl drive addr_i = {row, (i+1) mod 4} so no bank write occurs; row is the shared slot-0 row.
  - group++. If 4*(group+1) >= vl -> FIN, else READ.
- ISSUE, slow mode (1 beat per element, up to 4 per group):
  - A = base + elem*stride, computed as a running sum with wrap modulo 2^ADDR_W.
  - All four slots carry addr=A and data=the element, so only bank A[1:0] writes, at row A>>2.
  - elem++.
  - Last element (elem+1==vl) -> FIN.
  - Group boundary ((elem+1) mod 4 == 0) -> READ with group++.
  - Otherwise remain in ISSUE.
- FIN: done=1 and vs_valid=0 for one cycle, then IDLE.
- Outside ISSUE: vs_valid=0; addr and data outputs hold their last values.
- Stall:
  - No state or register advances.
  - vs_valid holds; a held beat repeats an identical write, which is idempotent and legal.
  - A stall asserted in READ keeps vrf_rd_en high, and the read repeats.
- Beat counts:
  - Fast mode: 2 cycles per group, ceil(vl/4) beats.
  - Slow mode: vl beats plus ceil(vl/4) READ cycles.
  - Start-to-done latency (no stall): fast = 2*ceil(vl/4)+1 cycles; slow = vl + ceil(vl/4) + 1 cycles.
- vl > MAXVL is clamped to MAXVL.
- Negative stride is legal; addresses wrap modulo 2^ADDR_W.

Decomposition:
- Shared package / constants.vh: state encodings (S_IDLE=0, S_READ=1, S_ISSUE=2, S_FIN=3), MAXVL, and the slot-suppress rule.
- One natural sub-module, vlsu_addr_gen: the running-address accumulator (load base on start, add stride or 4 per beat, wrap). The sequencer owns the FSM and the slot muxing.

Test Plan:
- Fast full groups: base=0x100, unit-stride, vl=8.
  - Beats at addr 0x100..0x103 and 0x104..0x107; vs_valid high 2 cycles total.
  - done at cycle 5 after start.
- Fast tail: base=0x40, vl=6.
  - Second beat: slots 0,1 at 0x44/0x45; slot 2 addr low bits 2'b11 and slot 3 low bits 2'b00, so banks 2 and 3 are not enabled.
- Misaligned unit-stride: base=0x21, vl=3.
  - Slow mode; single-element beats at 0x21, 0x22, 0x23, all slots equal.
  - Only banks 1, 2, 3 are enabled, in successive beats.
- Negative stride: base=0x10, stride=-3, vl=5.
  - Addresses 0x10, 0x0D, 0x0A, 0x07, 0x04; a READ cycle inserted before element 4.
- Stall and reset:
  - Stall 3 cycles mid-ISSUE: outputs frozen, sequence resumes unchanged.
  - nrst low during READ: all outputs 0 immediately, no done; a new start afterwards runs correctly.
- vl=0 and re-start: vl=0 gives done 1 cycle after start with vs_valid never high; a start while busy is ignored.
